// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/write-back bundle between the operand path and muldiv_unit.
interface muldiv_unit_if;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_idx_i;
   logic        busy_o;
   logic        wr_en_o;
   logic [4:0]  rd_idx_o;
   logic [31:0] rd_data_o;

   modport master (
      output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_idx_i,
      input  busy_o, wr_en_o, rd_idx_o, rd_data_o
   );

   modport slave (
      input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_idx_i,
      output busy_o, wr_en_o, rd_idx_o, rd_data_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide producing one register write-back beat.
// Define MULDIV_EARLY_OUT_EN to resolve zero/divide special cases in a single cycle.
module muldiv_unit (
   input  logic         clk_i,
   input  logic         rst_i,
   muldiv_unit_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned CNTW = 5;
   localparam int unsigned RIDW = 5;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                spec_q, spec_d;
   logic [XLEN-1:0]     spec_res_q, spec_res_d;
   logic                busy_q, busy_d;
   logic                wr_en_q, wr_en_d;
   logic [RIDW-1:0]     rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]     rd_data_q, rd_data_d;

   logic                sgn1_c, sgn2_c;
   logic [XLEN-1:0]     mag1_c, mag2_c;
   logic                spec_c;
   logic [XLEN-1:0]     spec_res_c;

   // Operand sign/magnitude and RISC-V special-case decode at issue
   always_comb begin
      logic [2:0]      f;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      f = bus.funct3_i;
      a = bus.rs1_data_i;
      b = bus.rs2_data_i;
      if (f[2]) begin
         sgn1_c = ~f[0] & a[XLEN-1];
         sgn2_c = ~f[0] & b[XLEN-1];
      end else begin
         sgn1_c = ((f == F_MULH) || (f == F_MULHSU)) & a[XLEN-1];
         sgn2_c = (f == F_MULH) & b[XLEN-1];
      end
      mag1_c     = sgn1_c ? (XLEN'(0) - a) : a;
      mag2_c     = sgn2_c ? (XLEN'(0) - b) : b;
      spec_c     = 1'b0;
      spec_res_c = '0;
      if (f[2]) begin
         if (b == '0) begin
            spec_c     = 1'b1;
            spec_res_c = f[1] ? a : '1;
         end else if (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            spec_c     = 1'b1;
            spec_res_c = f[1] ? 32'h0000_0000 : 32'h8000_0000;
         end
      end else if ((a == '0) || (b == '0)) begin
         spec_c = 1'b1;
      end
   end

   logic [2*XLEN-1:0] step_c;
   logic [XLEN-1:0]   res_c;

   // One shift-add or restoring-divide iteration, and the final result formatting
   always_comb begin
      logic [XLEN:0]     mul_sum;
      logic [XLEN:0]     div_rem;
      logic [XLEN-1:0]   div_diff;
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo;
      logic [XLEN-1:0]   rem;
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
      div_rem  = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_rem[XLEN-1:0] - b_q;
      if (op_q[2]) begin
         if (div_rem >= {1'b0, b_q}) step_c = {div_diff, acc_q[XLEN-2:0], 1'b1};
         else                        step_c = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         step_c = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod = neg_q ? ((2*XLEN)'(0) - step_c) : step_c;
      quo  = step_c[XLEN-1:0];
      rem  = step_c[2*XLEN-1:XLEN];
      if (op_q[2]) begin
         if (op_q[1]) res_c = rneg_q ? (XLEN'(0) - rem) : rem;
         else         res_c = neg_q  ? (XLEN'(0) - quo) : quo;
      end else begin
         res_c = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
      if (spec_q) res_c = spec_res_q;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      b_d        = b_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      wr_en_d    = 1'b0;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               op_d       = bus.funct3_i;
               b_d        = mag2_c;
               acc_d      = {XLEN'(0), mag1_c};
               neg_d      = sgn1_c ^ sgn2_c;
               rneg_d     = sgn1_c;
               spec_d     = spec_c;
               spec_res_d = spec_res_c;
               rd_idx_d   = bus.rd_idx_i;
               cnt_d      = CNTW'(31);
`ifdef MULDIV_EARLY_OUT_EN
               if (spec_c) begin
                  state_d   = DONE;
                  wr_en_d   = 1'b1;
                  rd_data_d = spec_res_c;
               end else begin
                  state_d   = CALC;
               end
`else
               state_d    = CALC;
`endif
            end
         end
         CALC: begin
            acc_d = step_c;
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == '0) begin
               state_d   = DONE;
               wr_en_d   = 1'b1;
               rd_data_d = res_c;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         busy_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_idx_q   <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         busy_q     <= busy_d;
         wr_en_q    <= wr_en_d;
         rd_idx_q   <= rd_idx_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.wr_en_o   = wr_en_q;
   assign bus.rd_idx_o  = rd_idx_q;
   assign bus.rd_data_o = rd_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, corner sequences and randomized ops against an arithmetic model.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   muldiv_unit_if bus ();
   muldiv_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // RV32M semantics with plain 64-bit and C-style signed arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb;
      int          ia, ib;
      bit          ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'({32'h0, b})); return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bit sp;
      if (f[2]) sp = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      else      sp = (a == 0) || (b == 0);
      return (EARLY && sp) ? 1 : 33;
   endfunction

   // Issue one op from IDLE (called at #1 after an edge) and check the write-back beat
   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int cyc;
      bus.start_i    = 1'b1;
      bus.funct3_i   = f;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.rd_idx_i   = rd;
      @(posedge clk); #1;
      bus.start_i    = 1'b0;
      bus.funct3_i   = 3'($urandom_range(0, 7));
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      bus.rd_idx_i   = 5'($urandom_range(0, 31));
      cyc = 1;
      check({nm, " busy"}, 64'(bus.busy_o), 64'd1);
      while (!bus.wr_en_o && cyc < 45) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({nm, " latency"}, 64'(cyc), 64'(exp_lat(f, a, b)));
      check({nm, " data"}, 64'(bus.rd_data_o), 64'(exp));
      check({nm, " rd"}, 64'(bus.rd_idx_o), 64'(rd));
      @(posedge clk); #1;
      check({nm, " idle busy/wr_en"}, {62'd0, bus.busy_o, bus.wr_en_o}, 64'd0);
      check({nm, " data hold"}, 64'(bus.rd_data_o), 64'(exp));
   endtask

   initial begin
      vec_t tbl[14];
      int   cyc;
      int   pulses;
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [31:0] edge_vals[4];

      tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      tbl[1]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 5'd6,  32'h0000_0006};
      tbl[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000};
      tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF};
      tbl[6]  = '{3'd5, 32'h0000_0064, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF};
      tbl[7]  = '{3'd7, 32'h0000_0064, 32'h0000_0000, 5'd12, 32'h0000_0064};
      tbl[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
      tbl[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
      tbl[10] = '{3'd0, 32'h0000_0000, 32'h1234_5678, 5'd0,  32'h0000_0000};
      tbl[11] = '{3'd4, 32'h1234_5678, 32'h0000_0000, 5'd31, 32'hFFFF_FFFF};
      tbl[12] = '{3'd6, 32'h8000_0001, 32'h0000_0000, 5'd1,  32'h8000_0001};
      tbl[13] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2,  32'hFFFF_FFFF};
      edge_vals[0] = 32'h0000_0000;
      edge_vals[1] = 32'h8000_0000;
      edge_vals[2] = 32'hFFFF_FFFF;
      edge_vals[3] = 32'h0000_0001;

      bus.start_i    = 1'b0;
      bus.funct3_i   = '0;
      bus.rs1_data_i = '0;
      bus.rs2_data_i = '0;
      bus.rd_idx_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", {bus.busy_o, bus.wr_en_o, bus.rd_idx_o, bus.rd_data_o}, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

      for (int i = 0; i < 150; i++) begin
         f = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
         run_op($sformatf("rnd%0d f%0d", i, f), f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
      end

      // start held through a whole op: second op accepted once IDLE is re-entered
      bus.start_i = 1'b1;  bus.funct3_i = 3'd0;  bus.rs1_data_i = 32'd3;
      bus.rs2_data_i = 32'd5;  bus.rd_idx_i = 5'd3;
      @(posedge clk); #1;
      bus.funct3_i = 3'd5;  bus.rs1_data_i = 32'd100;  bus.rs2_data_i = 32'd7;  bus.rd_idx_i = 5'd4;
      cyc = 1;
      while (!bus.wr_en_o && cyc < 45) begin @(posedge clk); #1; cyc++; end
      check("hold first latency", 64'(cyc), 64'd33);
      check("hold first data", 64'(bus.rd_data_o), 64'(model(3'd0, 32'd3, 32'd5)));
      check("hold first rd", 64'(bus.rd_idx_o), 64'd3);
      @(posedge clk); #1;
      check("hold idle gap", 64'(bus.busy_o), 64'd0);
      @(posedge clk); #1;
      check("hold second accept", 64'(bus.busy_o), 64'd1);
      bus.start_i = 1'b0;
      cyc = 1;
      while (!bus.wr_en_o && cyc < 45) begin @(posedge clk); #1; cyc++; end
      check("hold second latency", 64'(cyc), 64'd33);
      check("hold second data", 64'(bus.rd_data_o), 64'(model(3'd5, 32'd100, 32'd7)));
      check("hold second rd", 64'(bus.rd_idx_o), 64'd4);
      pulses = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.wr_en_o) pulses++; end
      check("hold no third op", 64'(pulses), 64'd0);

      // reset during CALC discards the operation
      bus.start_i = 1'b1;  bus.funct3_i = 3'd4;  bus.rs1_data_i = 32'd1000;
      bus.rs2_data_i = 32'd3;  bus.rd_idx_i = 5'd9;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midreset busy", 64'(bus.busy_o), 64'd0);
      check("midreset data", 64'(bus.rd_data_o), 64'd0);
      check("midreset rd", 64'(bus.rd_idx_o), 64'd0);
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.wr_en_o || bus.busy_o) pulses++; end
      check("midreset no write-back", 64'(pulses), 64'd0);

      run_op("post-reset MUL", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
